// File: rtl/register_file.sv
// Dual-write, dual-read 32 x 32 register file with write-first read bypass,
// read hold on rd_en low, and a registered same-address write conflict flag.
module register_file #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    write,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wr1,
    input  logic [AW-1:0] wa2,
    input  logic [DW-1:0] wr2,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          rd_en,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          wconf
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs [DEPTH];
    logic [DW-1:0] eff1;
    logic [DW-1:0] eff2;
    logic          conf;

    // Port 2 is checked last so it overrides port 1, matching the commit order below.
    always_comb begin
        conf = (write == 2'b11) && (wa1 == wa2);

        eff1 = regs[ra1];
        if (write[0] && (wa1 == ra1)) eff1 = wr1;
        if (write[1] && (wa2 == ra1)) eff1 = wr2;

        eff2 = regs[ra2];
        if (write[0] && (wa1 == ra2)) eff2 = wr1;
        if (write[1] && (wa2 == ra2)) eff2 = wr2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write[0]) regs[wa1] <= wr1;
            if (write[1]) regs[wa2] <= wr2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1   <= '0;
            rd2   <= '0;
            wconf <= 1'b0;
        end else begin
            wconf <= conf;
            if (rd_en) begin
                rd1 <= eff1;
                rd2 <= eff2;
            end
        end
    end

endmodule

// File: doc/register_file.md
# register_file

Dual-write, dual-read 32 x 32-bit general-purpose register file for CPU32. It is the consumer of the writeback stage's `write`/`wr1`/`wr2`/`wa1`/`wa2` bus: it commits up to two register writes per cycle. It serves two registered read ports to the operand-fetch stage, with write-first bypass and a read-hold (stall) control.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, address width; depth is 2^AW = 32 registers

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `write`  in  2  write enables; bit0 enables port 1, bit1 enables port 2
- `wa1`  in  AW  port-1 write address
- `wr1`  in  DW  port-1 write data
- `wa2`  in  AW  port-2 write address
- `wr2`  in  DW  port-2 write data
- `ra1`  in  AW  read-port-1 address
- `ra2`  in  AW  read-port-2 address
- `rd_en`  in  1  read enable; 0 holds both read outputs
- `rd1`  out  DW  read-port-1 data (registered)
- `rd2`  out  DW  read-port-2 data (registered)
- `wconf`  out  1  registered flag: the last edge saw both ports write the same address

## Operation
- **Storage:**
  - 32 registers, all writable.
  - There is no hardwired-zero register; address 0 is ordinary storage.
- **Write commit:**
  - On each rising edge, if `write[0]`, then `regs[wa1] <= wr1`.
  - If `write[1]`, then `regs[wa2] <= wr2`.
  - Every `write` encoding is honoured independently, including 2'b10, which the writeback stage does not issue.
- **Write conflict:**
  - Condition: `write == 2'b11` and `wa1 == wa2`.
  - Port 2 wins; `wr2` is stored and `wr1` is discarded.
  - `wconf` is set to 1 for that cycle. Otherwise `wconf` is 0 on every edge.
- **Read:**
  - When `rd_en = 1`, on each edge `rd1 <=` effective value of `ra1` and `rd2 <=` effective value of `ra2`.
  - When `rd_en = 0`, `rd1`/`rd2` hold their previous values. Writes still commit.
- **Effective value (write-first bypass)**, evaluated in this priority:
  - if `write[1]` and `wa2 == ra`, the value is `wr2`;
  - else if `write[0]` and `wa1 == ra`, the value is `wr1`;
  - else the value is `regs[ra]`.
  - This priority matches the conflict rule, so `rd` always equals the array contents immediately after the edge.
- **Reset (`rst` low, asynchronous):**
  - All 32 registers, `rd1`, `rd2` and `wconf` clear to 0 immediately, without waiting for a clock.
  - While `rst` is low, all inputs are ignored.
  - On `rst` deassertion, the first rising edge operates normally.
  - If reset asserts mid-cycle with a write pending, that write is lost.

## Timing
- **Write latency:** data presented before edge N is stored at edge N and is visible in `regs` from edge N onward.
- **Read latency:** one cycle.
  - `ra`, sampled at edge N, drives `rd` from just after edge N until the next enabled edge.
  - A write presented in the same cycle is reflected in `rd` at edge N (bypass).
  - A write presented one cycle later is not reflected until the next enabled read edge.
- **Stall:**
  - With `rd_en` low for k edges, `rd1`/`rd2` stay constant for those k edges.
  - The first edge with `rd_en` high samples the current `ra` against current contents, including any writes committed during the stall.
- **Combinational paths:** none from inputs to outputs; all outputs are flops.
- **Reset values:** `rd1 = 0`, `rd2 = 0`, `wconf = 0`, all registers 0.

## Test plan
- **Reset:**
  - Stimulus: pulse `rst` low asynchronously between edges, then read address 0 and address 31 with `rd_en = 1`.
  - Required: outputs go 0 before the next edge; `rd1 = 0`, `rd2 = 0`.
- **Single and dual write:**
  - Stimulus: `write = 01`, `wa1 = 3`, `wr1 = 0xDEADBEEF`; next cycle `write = 11` with `wa1 = 4`/`wr1 = 0x11`, `wa2 = 5`/`wr2 = 0x22`; then read `ra1 = 4`, `ra2 = 5`.
  - Required: `rd1 = 0x11`, `rd2 = 0x22`; reading address 3 returns 0xDEADBEEF.
- **Conflict:**
  - Stimulus: `write = 11`, `wa1 = wa2 = 7`, `wr1 = 0xAAAA`, `wr2 = 0xBBBB`.
  - Required: `wconf = 1` for exactly one cycle; a later read of 7 returns 0xBBBB.
- **Bypass:**
  - Stimulus: `ra1 = 9` and `write = 01`, `wa1 = 9`, `wr1 = 0x1234` in the same cycle.
  - Required: `rd1 = 0x1234` after that edge.
  - Stimulus: repeat with `write = 10`, `wa2 = 9`, `wr2 = 0x5678`, `ra2 = 9`.
  - Required: `rd2 = 0x5678`.
- **Stall:**
  - Stimulus: hold `rd_en = 0` for 3 cycles while writing 0xCAFE to the address on `ra1`.
  - Required: `rd1` unchanged for 3 edges, then 0xCAFE on the first enabled edge.
- **Port-2-only write plus reset mid-operation:**
  - Stimulus: `write = 10`, `wa2 = 0`, `wr2 = 0xF00D`.
  - Required: read of 0 returns 0xF00D.
  - Stimulus: assert `rst` low in the same cycle as a write to 0 of 0x1.
  - Required: read of 0 returns 0.
